// File: rtl/dram_cmd_seq.sv
// Single-request DRAM command sequencer: classifies each request against an
// open-row table, then issues PRE/ACT/RD/WR under tRP, tRCD and tCCD timing.
module dram_cmd_seq #(
  parameter int NUM_BG  = 4,
  parameter int NUM_BA  = 4,
  parameter int ROW_W   = 16,
  parameter int COL_W   = 10,
  parameter int T_RP    = 4,
  parameter int T_RCD   = 4,
  parameter int T_CCD_S = 4,
  parameter int T_CCD_L = 6,
  localparam int BG_W   = (NUM_BG > 1) ? $clog2(NUM_BG) : 1,
  localparam int BA_W   = (NUM_BA > 1) ? $clog2(NUM_BA) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [BG_W-1:0]  req_bg,
  input  logic [BA_W-1:0]  req_ba,
  input  logic [ROW_W-1:0] req_row,
  input  logic [COL_W-1:0] req_col,
  output logic             cmd_valid,
  output logic [2:0]       cmd_op,
  output logic [BG_W-1:0]  cmd_bg,
  output logic [BA_W-1:0]  cmd_ba,
  output logic [ROW_W-1:0] cmd_row,
  output logic [COL_W-1:0] cmd_col,
  output logic [1:0]       policy,
  output logic             done
);

  localparam int IDX_W   = BG_W + BA_W;
  localparam int NUM_ENT = 1 << IDX_W;
  localparam int CNT_W   = 8;
  localparam int COL_SAT = (T_CCD_L > T_RCD) ? T_CCD_L : T_RCD;
  localparam int CMD_SAT = (T_RP > T_RCD) ? T_RP : T_RCD;

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_WAIT_RP, S_ACT, S_WAIT_RCD, S_COL_WAIT, S_COL
  } state_e;

  typedef enum logic [2:0] {
    OP_NOP = 3'd0, OP_ACT = 3'd1, OP_PRE = 3'd2, OP_RD = 3'd3, OP_WR = 3'd4
  } op_e;

  typedef enum logic [1:0] {
    POL_NULL = 2'd0, POL_HIT = 2'd1, POL_MISS = 2'd2, POL_EMPTY = 2'd3
  } policy_e;

  state_e             state_q, state_d;
  logic               write_q, write_d;
  logic [BG_W-1:0]    bg_q, bg_d;
  logic [BA_W-1:0]    ba_q, ba_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [NUM_ENT-1:0] open_vld_q, open_vld_d;
  logic [ROW_W-1:0]   open_row_q [NUM_ENT];
  logic [ROW_W-1:0]   open_row_d [NUM_ENT];
  logic [CNT_W-1:0]   col_age_q, col_age_d, col_age_nx;
  logic [BG_W-1:0]    last_bg_q, last_bg_d;
  logic [CNT_W-1:0]   cmd_age_q, cmd_age_d, cmd_age_nx;

  logic               req_ready_q, req_ready_d;
  logic               cmd_valid_q, cmd_valid_d;
  op_e                cmd_op_q, cmd_op_d;
  logic [BG_W-1:0]    cmd_bg_q, cmd_bg_d;
  logic [BA_W-1:0]    cmd_ba_q, cmd_ba_d;
  logic [ROW_W-1:0]   cmd_row_q, cmd_row_d;
  logic [COL_W-1:0]   cmd_col_q, cmd_col_d;
  policy_e            policy_q, policy_d, cls;
  logic               done_q, done_d;

  logic               accept, ccd_ok, rp_ok, rcd_ok, tgt_write;
  logic [BG_W-1:0]    tgt_bg;
  logic [BA_W-1:0]    tgt_ba;
  logic [ROW_W-1:0]   tgt_row;
  logic [COL_W-1:0]   tgt_col;
  logic [IDX_W-1:0]   tgt_idx, cur_idx;

  // NOTE: every always_comb output gets a default before any branch so no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    accept = req_valid && req_ready_q;

    // In IDLE the live request is the target; afterwards the captured copy.
    tgt_write = (state_q == S_IDLE) ? req_write : write_q;
    tgt_bg    = (state_q == S_IDLE) ? req_bg    : bg_q;
    tgt_ba    = (state_q == S_IDLE) ? req_ba    : ba_q;
    tgt_row   = (state_q == S_IDLE) ? req_row   : row_q;
    tgt_col   = (state_q == S_IDLE) ? req_col   : col_q;
    tgt_idx   = {tgt_bg, tgt_ba};
    cur_idx   = {bg_q, ba_q};

    if (!open_vld_q[tgt_idx])             cls = POL_EMPTY;
    else if (open_row_q[tgt_idx] == tgt_row) cls = POL_HIT;
    else                                  cls = POL_MISS;

    // Ages as they will read in the next cycle, which is the candidate issue slot.
    col_age_nx = (col_age_q >= CNT_W'(COL_SAT)) ? CNT_W'(COL_SAT) : col_age_q + CNT_W'(1);
    cmd_age_nx = (cmd_age_q >= CNT_W'(CMD_SAT)) ? CNT_W'(CMD_SAT) : cmd_age_q + CNT_W'(1);
    ccd_ok = col_age_nx >= ((tgt_bg == last_bg_q) ? CNT_W'(T_CCD_L) : CNT_W'(T_CCD_S));
    rp_ok  = cmd_age_nx >= CNT_W'(T_RP);
    rcd_ok = cmd_age_nx >= CNT_W'(T_RCD);

    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          unique case (cls)
            POL_MISS:  state_d = S_PRE;
            POL_EMPTY: state_d = S_ACT;
            default:   state_d = ccd_ok ? S_COL : S_COL_WAIT;
          endcase
        end
      end
      S_PRE, S_WAIT_RP:       state_d = rp_ok ? S_ACT : S_WAIT_RP;
      S_ACT, S_WAIT_RCD: begin
        if (!rcd_ok)     state_d = S_WAIT_RCD;
        else if (ccd_ok) state_d = S_COL;
        else             state_d = S_COL_WAIT;
      end
      S_COL_WAIT:             state_d = ccd_ok ? S_COL : S_COL_WAIT;
      S_COL:                  state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase

    write_d = accept ? req_write : write_q;
    bg_d    = accept ? req_bg    : bg_q;
    ba_d    = accept ? req_ba    : ba_q;
    row_d   = accept ? req_row   : row_q;
    col_d   = accept ? req_col   : col_q;

    open_vld_d = open_vld_q;
    open_row_d = open_row_q;
    if (state_q == S_PRE) open_vld_d[cur_idx] = 1'b0;
    if (state_q == S_ACT) begin
      open_vld_d[cur_idx] = 1'b1;
      open_row_d[cur_idx] = row_q;
    end

    col_age_d = (state_d == S_COL) ? '0 : col_age_nx;
    last_bg_d = (state_d == S_COL) ? tgt_bg : last_bg_q;
    cmd_age_d = (state_d == S_PRE || state_d == S_ACT) ? '0 : cmd_age_nx;

    // Outputs are decoded from the next state so they line up with it when registered.
    cmd_valid_d = 1'b0;
    cmd_op_d    = OP_NOP;
    cmd_bg_d    = '0;
    cmd_ba_d    = '0;
    cmd_row_d   = '0;
    cmd_col_d   = '0;
    unique case (state_d)
      S_PRE: begin
        cmd_valid_d = 1'b1; cmd_op_d = OP_PRE; cmd_bg_d = tgt_bg; cmd_ba_d = tgt_ba;
      end
      S_ACT: begin
        cmd_valid_d = 1'b1; cmd_op_d = OP_ACT; cmd_bg_d = tgt_bg; cmd_ba_d = tgt_ba;
        cmd_row_d   = tgt_row;
      end
      S_COL: begin
        cmd_valid_d = 1'b1; cmd_op_d = tgt_write ? OP_WR : OP_RD;
        cmd_bg_d    = tgt_bg; cmd_ba_d = tgt_ba; cmd_col_d = tgt_col;
      end
      default: ;
    endcase
    policy_d    = accept ? cls : policy_q;
    done_d      = (state_d == S_COL);
    req_ready_d = (state_d == S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      write_q     <= 1'b0;
      bg_q        <= '0;
      ba_q        <= '0;
      row_q       <= '0;
      col_q       <= '0;
      open_vld_q  <= '0;
      col_age_q   <= CNT_W'(COL_SAT);
      last_bg_q   <= '0;
      cmd_age_q   <= CNT_W'(CMD_SAT);
      req_ready_q <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_op_q    <= OP_NOP;
      cmd_bg_q    <= '0;
      cmd_ba_q    <= '0;
      cmd_row_q   <= '0;
      cmd_col_q   <= '0;
      policy_q    <= POL_NULL;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      bg_q        <= bg_d;
      ba_q        <= ba_d;
      row_q       <= row_d;
      col_q       <= col_d;
      open_vld_q  <= open_vld_d;
      col_age_q   <= col_age_d;
      last_bg_q   <= last_bg_d;
      cmd_age_q   <= cmd_age_d;
      req_ready_q <= req_ready_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_op_q    <= cmd_op_d;
      cmd_bg_q    <= cmd_bg_d;
      cmd_ba_q    <= cmd_ba_d;
      cmd_row_q   <= cmd_row_d;
      cmd_col_q   <= cmd_col_d;
      policy_q    <= policy_d;
      done_q      <= done_d;
    end
  end

  // NOTE: row storage has no reset; the valid bits alone decide whether a row
  // is meaningful, which keeps the table a plain RAM-style array.
  always_ff @(posedge clk) begin
    open_row_q <= open_row_d;
  end

  assign req_ready = req_ready_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_op    = cmd_op_q;
  assign cmd_bg    = cmd_bg_q;
  assign cmd_ba    = cmd_ba_q;
  assign cmd_row   = cmd_row_q;
  assign cmd_col   = cmd_col_q;
  assign policy    = policy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_dram_cmd_seq.sv
// Bench for dram_cmd_seq: directed timing scenarios plus randomized traffic
// checked every cycle against a schedule-level reference model.
module tb_dram_cmd_seq;
  localparam int NUM_BG = 4, NUM_BA = 4, ROW_W = 16, COL_W = 10;
  localparam int T_RP = 4, T_RCD = 4, T_CCD_S = 4, T_CCD_L = 6;
  localparam int BG_W = 2, BA_W = 2;

  logic             clk, rst_n, req_valid, req_ready, req_write;
  logic [BG_W-1:0]  req_bg;
  logic [BA_W-1:0]  req_ba;
  logic [ROW_W-1:0] req_row;
  logic [COL_W-1:0] req_col;
  logic             cmd_valid, done;
  logic [2:0]       cmd_op;
  logic [BG_W-1:0]  cmd_bg;
  logic [BA_W-1:0]  cmd_ba;
  logic [ROW_W-1:0] cmd_row;
  logic [COL_W-1:0] cmd_col;
  logic [1:0]       policy;

  dram_cmd_seq #(
    .NUM_BG(NUM_BG), .NUM_BA(NUM_BA), .ROW_W(ROW_W), .COL_W(COL_W),
    .T_RP(T_RP), .T_RCD(T_RCD), .T_CCD_S(T_CCD_S), .T_CCD_L(T_CCD_L)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row),
    .req_col(req_col), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_bg(cmd_bg),
    .cmd_ba(cmd_ba), .cmd_row(cmd_row), .cmd_col(cmd_col), .policy(policy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the whole command schedule of a request is computed at acceptance.
  int cyc = 0;
  bit m_vld [NUM_BG*NUM_BA];
  int m_row [NUM_BG*NUM_BA];
  int last_col_cyc, last_col_bg;
  int pre_c, act_c, col_c, ready_c, acc_c;
  int m_policy, m_bg, m_ba, m_rw, m_col, m_wr;
  bit acc_flag;
  // Observations of DUT behaviour for the directed timing checks.
  int last_act, last_pre, last_done, n_act, n_pre, n_done;
  int dq[$];

  function automatic void model_reset();
    for (int i = 0; i < NUM_BG*NUM_BA; i++) m_vld[i] = 1'b0;
    last_col_cyc = -1000; last_col_bg = 0;
    pre_c = -1; act_c = -1; col_c = -1;
    ready_c = 1 << 30;
    m_policy = 0;
  endfunction

  function automatic void model_edge();
    int idx, earliest, spacing;
    acc_flag = 1'b0;
    if (!(rst_n && req_valid && cyc >= ready_c)) return;
    acc_flag = 1'b1; acc_c = cyc;
    idx = int'(req_bg) * NUM_BA + int'(req_ba);
    m_bg = int'(req_bg); m_ba = int'(req_ba); m_rw = int'(req_row);
    m_col = int'(req_col); m_wr = int'(req_write);
    pre_c = -1; act_c = -1;
    if (!m_vld[idx]) begin
      m_policy = 3; act_c = cyc + 1; earliest = act_c + T_RCD;
    end else if (m_row[idx] == m_rw) begin
      m_policy = 1; earliest = cyc + 1;
    end else begin
      m_policy = 2; pre_c = cyc + 1; act_c = pre_c + T_RP; earliest = act_c + T_RCD;
    end
    spacing = last_col_cyc + ((m_bg == last_col_bg) ? T_CCD_L : T_CCD_S);
    col_c = (spacing > earliest) ? spacing : earliest;
    ready_c = col_c + 1;
    m_vld[idx] = 1'b1; m_row[idx] = m_rw;
    last_col_cyc = col_c; last_col_bg = m_bg;
  endfunction

  task automatic check_outputs();
    int ev, eop, ebg, eba, erow, ecol, edone;
    ev = 0; eop = 0; ebg = 0; eba = 0; erow = 0; ecol = 0; edone = 0;
    if (cyc == pre_c) begin
      ev = 1; eop = 2; ebg = m_bg; eba = m_ba;
    end else if (cyc == act_c) begin
      ev = 1; eop = 1; ebg = m_bg; eba = m_ba; erow = m_rw;
    end else if (cyc == col_c) begin
      ev = 1; eop = m_wr ? 4 : 3; ebg = m_bg; eba = m_ba; ecol = m_col; edone = 1;
    end
    check("cmd_valid", 32'(cmd_valid), ev);
    check("cmd_op", 32'(cmd_op), eop);
    check("cmd_bg", 32'(cmd_bg), ebg);
    check("cmd_ba", 32'(cmd_ba), eba);
    check("cmd_row", 32'(cmd_row), erow);
    check("cmd_col", 32'(cmd_col), ecol);
    check("done", 32'(done), edone);
    check("policy", 32'(policy), m_policy);
    check("req_ready", 32'(req_ready), (cyc >= ready_c) ? 1 : 0);
    if (cmd_valid && cmd_op == 3'd1) begin n_act++; last_act = cyc; end
    if (cmd_valid && cmd_op == 3'd2) begin n_pre++; last_pre = cyc; end
    if (done) begin n_done++; last_done = cyc; dq.push_back(cyc); end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_cmd_valid", 32'(cmd_valid), 0);
    check("rst_cmd_op", 32'(cmd_op), 0);
    check("rst_policy", 32'(policy), 0);
    check("rst_ready", 32'(req_ready), 0);
    check("rst_done", 32'(done), 0);
    for (int i = 0; i < n; i++) tick();
    rst_n = 1'b1;
    ready_c = cyc + 1;
  endtask

  task automatic send(input bit w, input int bg, input int ba, input int row, input int col,
                      input bit keep);
    req_write = w; req_bg = BG_W'(bg); req_ba = BA_W'(ba);
    req_row = ROW_W'(row); req_col = COL_W'(col); req_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (acc_flag) break;
    end
    check("accept_within_bound", 32'(acc_flag), 1);
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && cyc < ready_c; i++) tick();
    check("idle_within_bound", (cyc >= ready_c) ? 1 : 0, 1);
  endtask

  task automatic rand_fields();
    req_write = 1'($urandom_range(0, 1));
    req_bg    = BG_W'($urandom_range(0, 3));
    req_ba    = BA_W'($urandom_range(0, 1));
    req_row   = ROW_W'($urandom_range(0, 2));
    req_col   = COL_W'($urandom_range(0, 1023));
  endtask

  initial begin
    int c, acts, base;
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    req_bg = '0; req_ba = '0; req_row = '0; req_col = '0;
    n_act = 0; n_pre = 0; n_done = 0; last_act = -1; last_pre = -1; last_done = -1;
    model_reset();
    @(negedge clk);
    do_reset(3);

    // Empty bank: ACT one cycle after acceptance, RD after tRCD.
    send(0, 0, 0, 5, 8, 0);
    check("pol_empty", 32'(policy), 3);
    wait_idle();
    check("act_lat_empty", last_act - acc_c, 1);
    check("rd_lat_empty", last_done - acc_c, 5);

    // Hit in the same bank group: spaced by tCCD_L from the previous RD.
    c = last_done; acts = n_act + n_pre;
    send(0, 0, 0, 5, 16, 0);
    check("pol_hit", 32'(policy), 1);
    wait_idle();
    check("acc_after_rd", acc_c - c, 1);
    check("rd_spacing_hit", last_done - c, 6);
    check("hit_no_act_pre", n_act + n_pre, acts);

    // Miss: PRE, ACT tRP later, WR tRCD after that.
    send(1, 0, 0, 9, 3, 0);
    check("pol_miss", 32'(policy), 2);
    wait_idle();
    check("pre_lat_miss", last_pre - acc_c, 1);
    check("act_after_pre", last_act - last_pre, 4);
    check("wr_after_pre", last_done - last_pre, 8);

    // Cross and same bank-group column spacing.
    send(0, 1, 0, 3, 1, 0); wait_idle();
    send(0, 0, 1, 7, 2, 0); wait_idle();
    send(0, 0, 0, 9, 4, 0);
    check("pol_row9_kept", 32'(policy), 1);
    wait_idle();
    c = last_done;
    send(1, 1, 0, 3, 5, 0); wait_idle();
    check("ccd_s_spacing", last_done - c, 4);
    send(0, 0, 0, 9, 6, 0); wait_idle();
    c = last_done;
    send(0, 0, 1, 7, 7, 0); wait_idle();
    check("ccd_l_spacing", last_done - c, 6);

    // Reset in WAIT_RP of a miss aborts it; the bank then reads as closed.
    send(0, 1, 0, 5, 0, 0);
    check("pol_miss2", 32'(policy), 2);
    tick();
    acts = n_act;
    do_reset(2);
    for (int i = 0; i < 6; i++) tick();
    check("no_act_after_rst", n_act, acts);
    send(0, 1, 0, 5, 0, 0);
    check("pol_empty_after_rst", 32'(policy), 3);
    wait_idle();

    // Back-to-back hits with req_valid held high across every acceptance.
    send(0, 2, 0, 1, 0, 0); wait_idle();
    base = n_done;
    for (int k = 0; k < 5; k++) send(0, 2, 0, 1, 100 + k, (k < 4) ? 1'b1 : 1'b0);
    wait_idle();
    check("b2b_done_count", n_done - base, 5);
    for (int k = 0; k < 5; k++)
      check("b2b_spacing", dq[dq.size()-1-k] - dq[dq.size()-2-k], 6);

    // Randomized traffic with occasional mid-sequence resets.
    for (int it = 0; it < 2500; it++) begin
      if ($urandom_range(0, 299) == 0) do_reset($urandom_range(1, 3));
      if (!req_valid && $urandom_range(0, 3) != 0) begin
        rand_fields();
        req_valid = 1'b1;
      end
      tick();
      if (acc_flag) begin
        if ($urandom_range(0, 1) == 1) rand_fields();
        else req_valid = 1'b0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dram_cmd_seq.md
DRAM_CMD_SEQ -- requirements
Module: dram_cmd_seq

Interface
REQ-001 Parameters: NUM_BG=4 (bank groups), NUM_BA=4 (banks per group), ROW_W=16, COL_W=10, T_RP=4, T_RCD=4, T_CCD_S=4, T_CCD_L=6. All timings are in clk cycles, each >=1.
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous and active-low.
REQ-004 req_valid  in  1  request present.
REQ-005 req_ready  out  1  sequencer can accept a request.
REQ-006 req_write  in  1  1=write, 0=read.
REQ-007 req_bg / req_ba / req_row / req_col  in  clog2(NUM_BG) / clog2(NUM_BA) / ROW_W / COL_W  target address.
REQ-008 cmd_valid  out  1  a DRAM command is issued this cycle.
REQ-009 cmd_op  out  3  0=NOP, 1=ACT, 2=PRE, 3=RD, 4=WR.
REQ-010 cmd_bg / cmd_ba / cmd_row / cmd_col  out  same widths as req_*  command address.
REQ-011 policy  out  2  classification of the accepted request: 0=NULL, 1=HIT, 2=MISS, 3=EMPTY.
REQ-012 done  out  1  one-cycle pulse in the cycle the request's RD/WR issues.

Function
REQ-013 All outputs are registered. A command "issues in cycle N" when cmd_valid=1 during cycle N.
REQ-014 Open-row table: one valid bit plus a ROW_W row per bank (NUM_BG*NUM_BA entries).
REQ-015 Acceptance: a request is accepted on a rising edge where req_valid && req_ready. req_ready=1 only in IDLE. Request fields are captured at acceptance.
REQ-016 Classification at acceptance:
  - target bank closed -> EMPTY
  - open with equal row -> HIT
  - open with other row -> MISS
  policy holds this value from the cycle after acceptance until the next acceptance.
REQ-017 FSM states: IDLE, PRE, WAIT_RP, ACT, WAIT_RCD, COL_WAIT, COL.
REQ-018 Transitions from acceptance:
  - MISS -> PRE
  - EMPTY -> ACT
  - HIT -> COL_WAIT
REQ-019 PRE (one cycle): issues PRE to the target bank and clears its valid bit, then enters WAIT_RP.
REQ-020 ACT is issued exactly T_RP cycles after PRE. ACT (one cycle) issues ACT with req_row, sets valid and row, then enters WAIT_RCD.
REQ-021 The column command is issued no earlier than T_RCD cycles after ACT.
REQ-022 Column spacing: the column command is also issued no earlier than T_CCD_L cycles after the previous column command to the same bank group, and no earlier than T_CCD_S cycles after one to a different bank group. It issues in the first cycle that satisfies all applicable constraints.
REQ-023 The first cycle eligible under REQ-021/022 is the cycle immediately following the preceding command or acceptance.
REQ-024 COL (one cycle): issues RD or WR with cmd_col=req_col, pulses done, then returns to IDLE. Rows stay open (open-page policy).
REQ-025 Column history: the cycles-since-last-column-command counter saturates at max(T_CCD_L, T_RCD) and never wraps. It holds the last column bank group. Before the first column command it reads as saturated.
REQ-026 Cycles with no command drive cmd_valid=0, cmd_op=NOP, and address outputs 0.
REQ-027 req_valid while busy is ignored (no acceptance). The requester must hold the request until it is accepted.
REQ-028 Request fields changing after acceptance have no effect.

Reset
REQ-029 While rst_n=0, asynchronously:
  - state = IDLE
  - all bank valid bits = 0
  - column history saturated
  - cmd_valid = 0, cmd_op = NOP, cmd addresses = 0
  - policy = NULL, done = 0, req_ready = 0
REQ-030 req_ready rises in the first cycle after rst_n deasserts.
REQ-031 Reset asserted mid-sequence aborts the sequence with no further commands. After release, all banks are treated as closed.

Verification
REQ-032 After reset, read bg0/ba0/row5/col8 accepted at the end of cycle 0 -> policy=EMPTY, ACT row5 in cycle 1, RD col8 in cycle 5 with done=1, req_ready=1 in cycle 6.
REQ-033 Then read bg0/ba0/row5/col16 accepted at the end of cycle 6 -> policy=HIT, RD in cycle 11 (T_CCD_L after cycle 5), no ACT/PRE.
REQ-034 Then write bg0/ba0/row9 -> policy=MISS; PRE in cycle P, ACT row9 in cycle P+4, WR in cycle P+8. The table then holds row9.
REQ-035 HIT to bg1 (open row), accepted the cycle after a bg0 RD at cycle C -> WR/RD in cycle C+4 (T_CCD_S). Same bank group, different bank -> C+6.
REQ-036 rst_n pulled low in WAIT_RP of a MISS -> no ACT issued, outputs at reset values. After release, a request to the same bank -> policy=EMPTY.
REQ-037 req_valid held high continuously with back-to-back HITs to the same bank group -> RD spacing is exactly 6 cycles, done pulses once per request, and no request is dropped or duplicated.
